// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Holds the state encoding and the rotating priority pick.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Returns the lowest set index. All-zero input returns 0; callers gate on |v.
  function automatic logic [IDX_W-1:0] first_set(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Rotate right by ptr so bit ptr becomes bit 0, pick the lowest set bit,
  // then rotate the index back. The 3-bit add wraps mod 8 for free.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    return first_set(rot) + ptr;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the eight masters and the arbiter.
// The master side drives req/done; the arbiter (slave) drives the grant outputs.
interface rr_arbiter_8_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_arbiter_8_grant_decode.sv
// 3-to-8 decoder with enable. Feeds the grant register in the parent,
// so the one-hot select is derived from the same next-state index it registers.
module grant_decode
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with owner release and optional hold timeout.
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate among req starting at ptr
// ST_GRANT | gnt_idx owns the slot until done, req drop or hold expiry
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter_8_if.slave bus
);

  localparam bit                HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             timeout_q, timeout_d;

  logic             owner_req;
  logic             hold_expired;
  logic             release_now;

  assign owner_req    = bus.req[idx_q];
  assign hold_expired = HOLD_EN && (hold_q == HOLD_LAST);
  assign release_now  = bus.done || !owner_req || hold_expired;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          idx_d   = rr_pick(bus.req, ptr_q);
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          valid_d   = 1'b0;
          ptr_d     = idx_q + 1'b1;
          state_d   = ST_IDLE;
          // Only a pure counter expiry is flagged; done or req drop take precedence.
          timeout_d = !bus.done && owner_req;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  grant_decode u_grant_decode (
    .idx    (idx_d),
    .en     (valid_d),
    .onehot (grant_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: one default instance, one with MAX_HOLD=4
// for the hold-timeout cases. Inputs change and outputs are sampled on negedge.
module tb_rr_arbiter_8;

  logic clk;
  logic rst_n;
  logic rst_nb;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [7:0] exp_g;

  rr_arbiter_8_if ifa ();
  rr_arbiter_8_if ifb ();

  rr_arbiter_8 dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  rr_arbiter_8 #(.MAX_HOLD(4), .HOLD_W(5)) dut_b (
    .clk   (clk),
    .rst_n (rst_nb),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach the end of its sequence");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] g, input logic v,
                       input logic [2:0] idx, input logic to);
    chk({tag, "_grant"}, ifa.grant, g);
    chk({tag, "_valid"}, {7'd0, ifa.gnt_valid}, {7'd0, v});
    chk({tag, "_idx"}, {5'd0, ifa.gnt_idx}, {5'd0, idx});
    chk({tag, "_timeout"}, {7'd0, ifa.timeout}, {7'd0, to});
  endtask

  task automatic chk_b(input string tag, input logic [7:0] g, input logic [2:0] idx,
                       input logic to);
    chk({tag, "_grant"}, ifb.grant, g);
    chk({tag, "_idx"}, {5'd0, ifb.gnt_idx}, {5'd0, idx});
    chk({tag, "_timeout"}, {7'd0, ifb.timeout}, {7'd0, to});
  endtask

  initial begin
    rst_n    = 1'b0;
    rst_nb   = 1'b0;
    ifa.req  = 8'hFF;
    ifa.done = 1'b0;
    ifb.req  = 8'h00;
    ifb.done = 1'b0;

    // Reset held two cycles with all requests high
    tick();
    tick();
    chk_a("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_a("first_grant", 8'h01, 1'b1, 3'd0, 1'b0);

    // Rotation with done on every grant: 02,04,...,80,01 with a gap each time
    for (int k = 1; k <= 8; k++) begin
      ifa.done = 1'b1;
      tick();
      chk("rot_gap", ifa.grant, 8'h00);
      ifa.done = 1'b0;
      tick();
      exp_g = 8'h01 << (k % 8);
      chk("rot_grant", ifa.grant, exp_g);
    end

    // Release idx 0 -> ptr 1
    ifa.done = 1'b1;
    ifa.req  = 8'h00;
    tick();
    chk_a("rot_end", 8'h00, 1'b0, 3'd0, 1'b0);
    ifa.done = 1'b0;

    // Single requester idx 4, done three cycles after grant
    ifa.req = 8'h10;
    tick();
    chk_a("single_grant", 8'h10, 1'b1, 3'd4, 1'b0);
    tick();
    chk("single_hold1", ifa.grant, 8'h10);
    tick();
    chk("single_hold2", ifa.grant, 8'h10);
    ifa.done = 1'b1;
    tick();
    chk_a("single_release", 8'h00, 1'b0, 3'd4, 1'b0);
    ifa.done = 1'b0;

    // ptr must now be 5: with req 0x21 the scan from 5 picks idx 5
    ifa.req = 8'h21;
    tick();
    chk_a("ptr5_pick", 8'h20, 1'b1, 3'd5, 1'b0);
    ifa.done = 1'b1;
    ifa.req  = 8'h00;
    tick();
    chk("ptr5_release", ifa.grant, 8'h00);
    ifa.done = 1'b0;

    // Serve idx 6 so ptr becomes 7, then req 0x41 wraps to idx 0 before idx 6
    ifa.req = 8'h40;
    tick();
    chk("wrap_serve6", ifa.grant, 8'h40);
    ifa.done = 1'b1;
    tick();
    chk("wrap_release6", ifa.grant, 8'h00);
    ifa.done = 1'b0;
    ifa.req  = 8'h41;
    tick();
    chk_a("wrap_idx0", 8'h01, 1'b1, 3'd0, 1'b0);
    ifa.done = 1'b1;
    tick();
    chk("wrap_gap", ifa.grant, 8'h00);
    ifa.done = 1'b0;
    tick();
    chk_a("wrap_idx6", 8'h40, 1'b1, 3'd6, 1'b0);

    // Owner dropping req releases without timeout; ptr -> 7
    ifa.req = 8'h00;
    tick();
    chk_a("drop_release", 8'h00, 1'b0, 3'd6, 1'b0);

    // req 0x0C from ptr 7 picks idx 2; dropping bit 2 hands over to idx 3
    ifa.req = 8'h0C;
    tick();
    chk_a("own_drop_grant2", 8'h04, 1'b1, 3'd2, 1'b0);
    ifa.req = 8'h08;
    tick();
    chk_a("own_drop_release", 8'h00, 1'b0, 3'd2, 1'b0);
    tick();
    chk_a("own_drop_grant3", 8'h08, 1'b1, 3'd3, 1'b0);

    // Other requesters appearing during GRANT change nothing
    ifa.req = 8'hFF;
    tick();
    chk_a("others_ignored", 8'h08, 1'b1, 3'd3, 1'b0);

    // Reset mid-grant drops grant on that edge
    rst_n = 1'b0;
    tick();
    chk_a("mid_reset", 8'h00, 1'b0, 3'd0, 1'b0);
    rst_n   = 1'b1;
    ifa.req = 8'h00;
    tick();
    chk("post_reset_idle", ifa.grant, 8'h00);

    // Timeout instance: grant for exactly 4 cycles then a timeout pulse
    rst_nb = 1'b1;
    tick();
    chk_b("b_idle", 8'h00, 3'd0, 1'b0);
    ifb.req = 8'h04;
    tick();
    chk_b("to_cyc1", 8'h04, 3'd2, 1'b0);
    tick();
    chk_b("to_cyc2", 8'h04, 3'd2, 1'b0);
    tick();
    chk_b("to_cyc3", 8'h04, 3'd2, 1'b0);
    tick();
    chk_b("to_cyc4", 8'h04, 3'd2, 1'b0);
    tick();
    chk_b("to_release", 8'h00, 3'd2, 1'b1);
    chk("to_valid_low", {7'd0, ifb.gnt_valid}, 8'h00);
    tick();
    chk_b("to_regrant", 8'h04, 3'd2, 1'b0);

    // Same hold, but done arrives in the 4th cycle: no timeout pulse
    tick();
    chk_b("tod_cyc2", 8'h04, 3'd2, 1'b0);
    tick();
    chk_b("tod_cyc3", 8'h04, 3'd2, 1'b0);
    tick();
    chk_b("tod_cyc4", 8'h04, 3'd2, 1'b0);
    ifb.done = 1'b1;
    tick();
    chk_b("tod_release", 8'h00, 3'd2, 1'b0);
    ifb.done = 1'b0;
    ifb.req  = 8'h00;
    tick();
    chk_b("tod_idle", 8'h00, 3'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
